// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encodings and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_LDST   = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = PORT_LDST;
    end else begin
      grant_idx = PORT_IFETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto one synchronous RAM,
// sequencing each single-word access through IDLE -> ACCESS -> RESP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [addr_width-1:0] addr0,
  input  logic [data_width-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [data_width-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [data_width-1:0] rdata1,
  output logic [addr_width-1:0] mem_read_address,
  output logic [addr_width-1:0] mem_write_address,
  output logic                  mem_write,
  output logic [data_width-1:0] mem_din,
  input  logic [data_width-1:0] mem_dout
);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  idx_q, idx_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  mem_write_q, mem_write_d;
  logic [data_width-1:0] din_q, din_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [data_width-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  grant_valid, grant_idx;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    mem_write_d  = 1'b0;
    din_d        = din_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          idx_d        = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ACCESS;
          if (grant_idx == PORT_LDST) begin
            addr_d      = addr1;
            mem_write_d = we1;
            din_d       = wdata1;
            gnt1_d      = 1'b1;
          end else begin
            addr_d      = addr0;
            mem_write_d = we0;
            din_d       = wdata0;
            gnt0_d      = 1'b1;
          end
        end
      end
      ACCESS: state_d = RESP;
      // RAM output now holds the pre-write contents of the latched address
      RESP: begin
        state_d = IDLE;
        if (idx_q == PORT_LDST) begin
          rvalid1_d = 1'b1;
          rdata1_d  = mem_dout;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = mem_dout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_LDST;
      idx_q        <= PORT_IFETCH;
      addr_q       <= '0;
      mem_write_q  <= 1'b0;
      din_q        <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      mem_write_q  <= mem_write_d;
      din_q        <= din_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign gnt0              = gnt0_q;
  assign gnt1              = gnt1_q;
  assign rvalid0           = rvalid0_q;
  assign rvalid1           = rvalid1_q;
  assign rdata0            = rdata0_q;
  assign rdata1            = rdata1_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write         = mem_write_q;
  assign mem_din           = din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with an attached read-before-write RAM and a transaction-level reference.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, rvalid0, gnt1, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic          mem_write;
  logic [DW-1:0] mem_din, mem_dout;

  mem_arbiter #(.data_width(DW), .addr_width(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write(mem_write), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // RAM with registered read-before-write output and a backdoor preload port
  logic [DW-1:0] ram [DEPTH];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_write) ram[mem_write_address] <= mem_din;
    mem_dout <= ram[mem_read_address];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 3) return 32'h0000_00A5;
    if (i == 5) return 32'h0000_0011;
    if (i < 3) return 32'h100 + DW'(i);
    return DW'(i);
  endfunction

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = AW'(i); bd_data = init_val(i);
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic clear_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {gnt1, gnt0}, 0);
    check({tag, "_rvalid"}, {rvalid1, rvalid0}, 0);
    check({tag, "_rdata0"}, rdata0, 0);
    check({tag, "_rdata1"}, rdata1, 0);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_mem_addr"}, {mem_read_address, mem_write_address}, 0);
    check({tag, "_mem_din"}, mem_din, 0);
  endtask

  // One isolated transaction: request in an IDLE cycle, then verify grant, access, response timing
  task automatic do_txn(input int port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    @(negedge clk);
    if (port == 0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    else           begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    @(negedge clk);
    check("txn_gnt", {gnt1, gnt0}, (port == 0) ? 2'b01 : 2'b10);
    check("txn_mem_write", mem_write, we);
    check("txn_raddr", mem_read_address, addr);
    check("txn_waddr", mem_write_address, addr);
    if (we) check("txn_din", mem_din, wd);
    req0 = 0; req1 = 0;
    @(negedge clk);
    check("txn_resp_quiet", {gnt1, gnt0, rvalid1, rvalid0, mem_write}, 0);
    @(negedge clk);
    check("txn_rvalid", {rvalid1, rvalid0}, (port == 0) ? 2'b01 : 2'b10);
    check("txn_rdata", (port == 0) ? rdata0 : rdata1, exp_rd);
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[7];

  // Reference model state for the random phase
  logic [DW-1:0] mm [DEPTH];
  int            busy, cur_p, lg;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wd, old_word;
  logic [1:0]    e_gnt, e_rv;
  logic          e_mw;
  logic [DW-1:0] e_rd [2];
  logic          p_req [2];
  logic          p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wd [2];

  task automatic new_req(input int p);
    p_req[p] = 1'b1;
    p_we[p] = 1'($urandom_range(0, 1));
    p_addr[p] = AW'($urandom_range(0, DEPTH - 1));
    p_wd[p] = $urandom;
  endtask

  initial begin
    int gp[$];
    int gc[$];
    int raise_p;

    tbl[0] = '{0, 1'b0, 4'd3, 32'h0, 32'h0000_00A5};
    tbl[1] = '{1, 1'b1, 4'd5, 32'hDEAD_BEEF, 32'h0000_0011};
    tbl[2] = '{0, 1'b0, 4'd5, 32'h0, 32'hDEAD_BEEF};
    tbl[3] = '{1, 1'b0, 4'd0, 32'h0, 32'h0000_0100};
    tbl[4] = '{1, 1'b0, 4'd1, 32'h0, 32'h0000_0101};
    tbl[5] = '{1, 1'b0, 4'd2, 32'h0, 32'h0000_0102};
    tbl[6] = '{1, 1'b0, 4'd3, 32'h0, 32'h0000_00A5};

    // Reset with random inputs
    reset_n = 0;
    clear_inputs();
    fork
      preload();
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        req0 = 1'($urandom); we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = $urandom;
        req1 = 1'($urandom); we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = $urandom;
        #1 check_all_zero("reset");
      end
    join
    @(negedge clk);
    clear_inputs();
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_gnt", {gnt1, gnt0, rvalid1, rvalid0}, 0);
      check("idle_mem_write", mem_write, 0);
    end

    // Table-driven single transactions, back-to-back on port 1 for the tail
    for (int i = 0; i < 7; i++)
      do_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    // Tie and round-robin with both requests held from reset
    @(negedge clk);
    reset_n = 0;
    clear_inputs();
    req0 = 1; req1 = 1;
    @(negedge clk);
    reset_n = 1;
    raise_p = -1;
    for (int cyc = 0; cyc < 30 && gp.size() < 4; cyc++) begin
      @(negedge clk);
      if (raise_p == 0) req0 = 1;
      if (raise_p == 1) req1 = 1;
      raise_p = -1;
      if (gnt0) begin gp.push_back(0); gc.push_back(cyc); req0 = 0; raise_p = 0; end
      if (gnt1) begin gp.push_back(1); gc.push_back(cyc); req1 = 0; raise_p = 1; end
    end
    check("tie_grant_count", gp.size(), 4);
    for (int i = 0; i < gp.size() && i < 4; i++) begin
      check("tie_order", gp[i], i % 2);
      if (i > 0) check("tie_spacing", gc[i] - gc[i-1], 3);
    end
    clear_inputs();
    repeat (4) @(negedge clk);

    // Reset landing during the ACCESS cycle of a write
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    check("midrst_mem_write_before", mem_write, 1);
    check("midrst_gnt0_before", gnt0, 1);
    req0 = 0;
    #2 reset_n = 0;
    #1;
    check("midrst_mem_write_async", mem_write, 0);
    check("midrst_gnt0_async", gnt0, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_rvalid", {rvalid1, rvalid0}, 0);
    end
    do_txn(0, 1'b0, 4'd7, 32'h0, 32'h0000_0007);

    // Random traffic against the transaction-level model
    @(negedge clk);
    reset_n = 0;
    clear_inputs();
    preload();
    for (int i = 0; i < DEPTH; i++) mm[i] = init_val(i);
    busy = 0; lg = 1; cur_p = 0; cur_we = 0; cur_addr = '0; cur_wd = '0; old_word = '0;
    e_gnt = '0; e_rv = '0; e_mw = 0; e_rd[0] = '0; e_rd[1] = '0;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_we[p] = 0; p_addr[p] = '0; p_wd[p] = '0;
    end
    @(negedge clk);
    reset_n = 1;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clk);
      check("rnd_gnt", {gnt1, gnt0}, e_gnt);
      check("rnd_rvalid", {rvalid1, rvalid0}, e_rv);
      check("rnd_rdata0", rdata0, e_rd[0]);
      check("rnd_rdata1", rdata1, e_rd[1]);
      check("rnd_mem_write", mem_write, e_mw);
      if (e_gnt != 0) check("rnd_mem_addr", mem_read_address, cur_addr);

      for (int p = 0; p < 2; p++) begin
        if (e_gnt[p]) begin
          p_req[p] = 0;
          if ($urandom_range(0, 1) == 1) new_req(p);
        end else if (!p_req[p] && $urandom_range(0, 2) == 0) begin
          new_req(p);
        end
      end
      req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
      req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];

      e_gnt = '0; e_rv = '0; e_mw = 0;
      if (busy == 0) begin
        if (p_req[0] || p_req[1]) begin
          if (p_req[0] && p_req[1]) cur_p = 1 - lg;
          else cur_p = p_req[1] ? 1 : 0;
          lg = cur_p;
          cur_we = p_we[cur_p]; cur_addr = p_addr[cur_p]; cur_wd = p_wd[cur_p];
          e_gnt[cur_p] = 1'b1;
          e_mw = cur_we;
          busy = 2;
        end
      end else if (busy == 2) begin
        old_word = mm[cur_addr];
        if (cur_we) mm[cur_addr] = cur_wd;
        busy = 1;
      end else begin
        e_rv[cur_p] = 1'b1;
        e_rd[cur_p] = old_word;
        busy = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the synchronous single-clock RAM (1-cycle registered read, write-enable port).
- Port 0 is instruction fetch and port 1 is load/store. Both share one RAM instance, and the arbiter drives all RAM control, address and data inputs.
- Each transaction is a single word read or write. Every transaction, read or write, ends with a response pulse carrying the RAM's registered read data.

Parameters:
- data_width, 32, word width; must match the RAM.
- addr_width, 4, address width; must match the RAM.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held until gnt0.
- we0  in  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  in  addr_width  port 0 word address.
- wdata0  in  data_width  port 0 write data.
- gnt0  out  1  one-cycle pulse: port 0 request accepted.
- rvalid0  out  1  one-cycle pulse: port 0 transaction complete.
- rdata0  out  data_width  port 0 response data; valid when rvalid0 is high.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as the port 0 signals, for port 1.
- mem_read_address  out  addr_width  to RAM read_address.
- mem_write_address  out  addr_width  to RAM write_address.
- mem_write  out  1  to RAM write.
- mem_din  out  data_width  to RAM din.
- mem_dout  in  data_width  from RAM dout.

Behaviour:
- Reset is asynchronous: the instant reset_n goes low, all outputs are 0, state is IDLE, and last_grant is 1.
  - Because last_grant resets to 1, port 0 wins the first tie.
- All outputs are registered; there are no combinational input-to-output paths.
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - If req0 or req1 is high at the edge, pick a winner:
    - only one requesting: that port wins;
    - both requesting: the port != last_grant wins.
  - At that edge: latch the winner's addr/we/wdata into the mem_* registers, set gnt_winner=1, set mem_write=we, update last_grant, go to ACCESS.
  - If neither port requests, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - gnt_winner is high for this cycle only.
  - mem_read_address = mem_write_address = latched address.
  - mem_write = latched we. The RAM samples this at the edge ending ACCESS.
  - At that edge: mem_write is cleared and the FSM goes to RESP.
- RESP (exactly 1 cycle):
  - mem_dout holds the RAM contents at the latched address as they were before any write in this transaction (RAM read-before-write).
  - At the edge ending RESP: rdata_winner <= mem_dout, rvalid_winner <= 1, go to IDLE.
- Response data: a read returns the stored word; a write returns the old word.
- Latency: with request sampled at edge E0, gnt is high in cycle E0..E1 and rvalid is high in cycle E2..E3.
- Throughput: one transaction per 3 cycles. A new request can be sampled in the same IDLE cycle that rvalid is high.
- rdata_x holds its value until the next response on that port; it is not cleared when rvalid drops.
- Request protocol: the requester must drop req or present the next request after seeing gnt. req is ignored during ACCESS and RESP. A req still high in IDLE is a new transaction.
- Mid-transaction reset:
  - reset during ACCESS clears mem_write immediately (asynchronously), so the write is aborted and memory is unchanged if reset lands before the edge;
  - no rvalid is issued after reset, and the in-flight response is discarded.
- Address and width rules: no arithmetic is performed; addresses pass through unmodified. Every address 0..2**addr_width-1 is legal, with no wrap logic.

Decomposition:
- Shared package mem_arb_pkg holds:
  - FSM state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - port index constants PORT_IFETCH=0, PORT_LDST=1.
- One sub-module: rr_arb2, a 2-way round-robin picker.
  - Inputs: req0, req1, last_grant.
  - Outputs: grant_valid, grant_idx.
  - Combinational; its result is registered by mem_arbiter.

Test Plan:
- Reset: hold reset_n low with random inputs -> all outputs 0. Release reset_n with no req -> stays IDLE, mem_write never 1.
- Single read: RAM preloaded mem[3]=32'h000000A5, req0=1 we0=0 addr0=3 sampled at edge E0 -> gnt0 high in cycle E0..E1, rvalid0 high in E2..E3, rdata0=32'h000000A5, gnt1/rvalid1 stay 0.
- Write returns old data: mem[5]=32'h00000011, port 1 writes 32'hDEADBEEF to addr 5 -> rvalid1 with rdata1=32'h00000011. A following port 0 read of addr 5 -> rdata0=32'hDEADBEEF.
- Tie and round-robin: req0 and req1 both held high from reset, each dropping its request after its gnt and re-raising it in the next IDLE -> grant order 0,1,0,1 with a 3-cycle spacing between gnt pulses.
- Back-to-back single port: port 1 issues reads to addr 0,1,2,3, advancing addr after each gnt1 -> rvalid1 every 3 cycles with rdata1 equal to the preloaded mem[0..3]; port 0 idle throughout.
- Reset mid-write: port 0 writes 32'hCAFEF00D to addr 7 (old value 32'h7), reset_n pulsed low during ACCESS -> mem_write drops immediately, no rvalid0. A read of addr 7 after reset returns 32'h00000007.
